// File: rtl/multi_transfer_sequencer.sv
// Load/store-multiple engine: walks a register list, issues one memory word
// access per listed register and optionally writes back the updated base.
module multi_transfer_sequencer #(
   parameter int DATA_W = 32,
   parameter int STEP   = 4
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              START,
   input  logic              L,
   input  logic              U,
   input  logic              P,
   input  logic              W,
   input  logic [15:0]       RLIST,
   input  logic [3:0]        RN,
   input  logic [DATA_W-1:0] BASE,
   input  logic              MOC,
   input  logic [DATA_W-1:0] MEM_DIN,
   input  logic [DATA_W-1:0] PD_IN,
   output logic              BUSY,
   output logic              DONE,
   output logic              MEM_EN,
   output logic              MEM_RW,
   output logic [DATA_W-1:0] MEM_ADDR,
   output logic [DATA_W-1:0] MEM_DOUT,
   output logic [3:0]        SD,
   output logic [3:0]        C,
   output logic [DATA_W-1:0] PW,
   output logic              RFLd,
   output logic              PCLd
);

   typedef enum logic [2:0] {IDLE, SETUP, ACCESS, LOADWR, WB, FIN} state_t;

   state_t            state, state_next;
   logic              l_reg, u_reg, p_reg, w_reg;
   logic [15:0]       rlist_reg, rem_reg;
   logic [3:0]        rn_reg, cur_reg;
   logic [DATA_W-1:0] base_reg, addr_reg, final_reg, data_reg;
   logic [DATA_W-1:0] span, start_addr, final_base;
   logic              last_xfer, wb_en;

   function automatic logic [4:0] popcount16(input logic [15:0] v);
      logic [4:0] n;
      n = '0;
      for (int i = 0; i < 16; i++) n = n + {4'b0, v[i]};
      return n;
   endfunction

   function automatic logic [3:0] lowest_bit(input logic [15:0] v);
      logic [3:0] r;
      r = '0;
      for (int i = 15; i >= 0; i--) if (v[i]) r = 4'(i);
      return r;
   endfunction

   // Transfers always run at ascending addresses, so a decrementing block
   // starts at the bottom of the span it covers.
   assign span = DATA_W'(STEP) * DATA_W'(popcount16(rlist_reg));

   always_comb begin
      case ({u_reg, p_reg})
         2'b10:   start_addr = base_reg;
         2'b11:   start_addr = base_reg + DATA_W'(STEP);
         2'b00:   start_addr = base_reg - span + DATA_W'(STEP);
         default: start_addr = base_reg - span;
      endcase
   end

   assign final_base = u_reg ? (base_reg + span) : (base_reg - span);
   assign last_xfer  = (rem_reg == 16'h0);
   // A loaded base register keeps the loaded value rather than the writeback.
   assign wb_en      = w_reg && !(l_reg && rlist_reg[rn_reg]);

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) state <= IDLE;
      else     state <= state_next;
   end

   always_comb begin
      state_next = state;
      BUSY       = (state != IDLE);
      DONE       = 1'b0;
      MEM_EN     = 1'b0;
      MEM_RW     = 1'b0;
      MEM_ADDR   = addr_reg;
      MEM_DOUT   = '0;
      SD         = cur_reg;
      C          = cur_reg;
      PW         = data_reg;
      RFLd       = 1'b0;
      PCLd       = 1'b0;
      case (state)
         IDLE:   if (START) state_next = SETUP;
         SETUP:  state_next = (rlist_reg == 16'h0) ? FIN : ACCESS;
         ACCESS: begin
            MEM_EN   = 1'b1;
            MEM_RW   = l_reg;
            MEM_DOUT = PD_IN;
            if (MOC) begin
               if (l_reg)           state_next = LOADWR;
               else if (!last_xfer) state_next = ACCESS;
               else                 state_next = wb_en ? WB : FIN;
            end
         end
         LOADWR: begin
            RFLd = 1'b1;
            PCLd = (cur_reg == 4'd15);
            if (!last_xfer) state_next = ACCESS;
            else            state_next = wb_en ? WB : FIN;
         end
         WB: begin
            C          = rn_reg;
            PW         = final_reg;
            RFLd       = 1'b1;
            PCLd       = (rn_reg == 4'd15);
            state_next = FIN;
         end
         FIN: begin
            DONE       = 1'b1;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         l_reg     <= 1'b0;
         u_reg     <= 1'b0;
         p_reg     <= 1'b0;
         w_reg     <= 1'b0;
         rlist_reg <= '0;
         rem_reg   <= '0;
         rn_reg    <= '0;
         cur_reg   <= '0;
         base_reg  <= '0;
         addr_reg  <= '0;
         final_reg <= '0;
         data_reg  <= '0;
      end else begin
         case (state)
            IDLE: if (START) begin
               l_reg     <= L;
               u_reg     <= U;
               p_reg     <= P;
               w_reg     <= W;
               rlist_reg <= RLIST;
               rn_reg    <= RN;
               base_reg  <= BASE;
            end
            SETUP: begin
               addr_reg  <= start_addr;
               final_reg <= final_base;
               cur_reg   <= lowest_bit(rlist_reg);
               rem_reg   <= rlist_reg & (rlist_reg - 16'd1);
            end
            ACCESS: if (MOC) begin
               if (l_reg) begin
                  data_reg <= MEM_DIN;
               end else begin
                  addr_reg <= addr_reg + DATA_W'(STEP);
                  if (!last_xfer) begin
                     cur_reg <= lowest_bit(rem_reg);
                     rem_reg <= rem_reg & (rem_reg - 16'd1);
                  end
               end
            end
            LOADWR: begin
               addr_reg <= addr_reg + DATA_W'(STEP);
               if (!last_xfer) begin
                  cur_reg <= lowest_bit(rem_reg);
                  rem_reg <= rem_reg & (rem_reg - 16'd1);
               end
            end
            default: ;
         endcase
      end
   end

endmodule
